// File: rtl/key_encode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_encode_ctrl
// Description : Sequencing controller for a 16-key priority-encode and
//               BCD display path.
//               - Synchronises 16 active-low key lines through two flops.
//               - Debounces presses and releases.
//               - Latches the highest-priority key code and offers it to a
//                 consumer with a valid/ack handshake.
//               - Scans a two-digit, active-low-enable 7-segment display
//                 that shows 00..15.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               data_in  - key lines, active-low, bit 15 = highest priority
//               ack      - consumer accepts code; only honoured while valid
//               code     - latched key index 0..15
//               valid    - code available, held until ack
//               key_down - high in PRESSED and WAIT_REL
//               over     - displayed code is greater than 9
//               seg      - segment drive, active-high, [6:0]=g..a, [7]=dp
//               dig_sel  - digit enable, active-low, [0]=ones, [1]=tens
// Revision    : 1.0 - initial release
// ============================================================================
module key_encode_ctrl #(
    parameter int DB_CYCLES = 1000,
    parameter int SCAN_DIV  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        ack,
    output logic [3:0]  code,
    output logic        valid,
    output logic        key_down,
    output logic        over,
    output logic [7:0]  seg,
    output logic [1:0]  dig_sel
);

    localparam int CNT_W  = $clog2(DB_CYCLES);
    // A single-cycle scan period still needs a one-bit counter to exist.
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEB      = 2'd1,
        PRESSED  = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [15:0]        sync1, s_dat;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         cand, cand_nxt;
    logic [3:0]         code_nxt;
    logic               valid_nxt;
    logic [3:0]         disp, disp_nxt;
    logic               disp_v, disp_v_nxt;
    logic [SCAN_W-1:0]  scan_cnt;
    logic               any;
    logic [3:0]         rc;

    // Raw priority encode of the synchronised lines; the ascending loop
    // lets the highest asserted index win.
    always_comb begin
        any = |(~s_dat);
        rc  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!s_dat[i]) rc = 4'(i);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cand_nxt   = cand;
        code_nxt   = code;
        valid_nxt  = valid;
        disp_nxt   = disp;
        disp_v_nxt = disp_v;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = DEB;
                    cand_nxt  = rc;
                    cnt_nxt   = '0;
                end
            end
            DEB: begin
                // A release or a higher key joining restarts via IDLE.
                if (!any || (rc != cand)) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt  = PRESSED;
                    code_nxt   = cand;
                    valid_nxt  = 1'b1;
                    disp_nxt   = cand;
                    disp_v_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (ack && valid) begin
                    valid_nxt = 1'b0;
                    state_nxt = WAIT_REL;
                    cnt_nxt   = '0;
                end
            end
            WAIT_REL: begin
                if (any) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            s_dat  <= '1;
            state  <= IDLE;
            cnt    <= '0;
            cand   <= '0;
            code   <= '0;
            valid  <= 1'b0;
            disp   <= '0;
            disp_v <= 1'b0;
        end else begin
            sync1  <= data_in;
            s_dat  <= sync1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cand   <= cand_nxt;
            code   <= code_nxt;
            valid  <= valid_nxt;
            disp   <= disp_nxt;
            disp_v <= disp_v_nxt;
        end
    end

    assign key_down = (state == PRESSED) || (state == WAIT_REL);
    assign over     = disp_v && (disp > 4'd9);

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 7'h3F;
            4'd1:    seg_lut = 7'h06;
            4'd2:    seg_lut = 7'h5B;
            4'd3:    seg_lut = 7'h4F;
            4'd4:    seg_lut = 7'h66;
            4'd5:    seg_lut = 7'h6D;
            4'd6:    seg_lut = 7'h7D;
            4'd7:    seg_lut = 7'h07;
            4'd8:    seg_lut = 7'h7F;
            4'd9:    seg_lut = 7'h6F;
            default: seg_lut = 7'h00;
        endcase
    endfunction

    logic       scan_wrap;
    logic [1:0] dig_sel_nxt;
    logic [3:0] ones;
    logic [7:0] seg_nxt;

    always_comb begin
        scan_wrap   = (scan_cnt == SCAN_MAX);
        dig_sel_nxt = scan_wrap ? ~dig_sel : dig_sel;
        ones        = (disp > 4'd9) ? (disp - 4'd10) : disp;
        seg_nxt     = 8'h00;
        // Segments are computed for the digit that will be enabled after
        // this edge so seg and dig_sel always change together.
        if (disp_v) begin
            if (dig_sel_nxt == 2'b10) begin
                seg_nxt = {1'b0, seg_lut(ones)};
            end else if (disp > 4'd9) begin
                seg_nxt = {1'b0, seg_lut(4'd1)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_sel  <= 2'b10;
            seg      <= 8'h00;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            dig_sel  <= dig_sel_nxt;
            seg      <= seg_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_encode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_encode_ctrl
// Description : Directed self-checking bench for key_encode_ctrl with
//               DB_CYCLES=4 and SCAN_DIV=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_encode_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        ack;
    logic [3:0]  code;
    logic        valid;
    logic        key_down;
    logic        over;
    logic [7:0]  seg;
    logic [1:0]  dig_sel;

    int pass_cnt  = 0;
    int total_cnt = 0;

    key_encode_ctrl #(
        .DB_CYCLES(4),
        .SCAN_DIV (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .key_down(key_down),
        .over    (over),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for valid; n counts edges taken.
    task automatic wait_valid(input int max, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < max && !ok) begin
            step(1);
            n++;
            if (valid) ok = 1'b1;
        end
    endtask

    task automatic do_ack;
        @(negedge clk);
        ack = 1'b1;
        step(1);
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic release_keys;
        @(negedge clk);
        data_in = 16'hFFFF;
        step(10);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        data_in = 16'hFFFF;
        ack     = 1'b0;
        #23;
        total_cnt++;
        if (valid !== 1'b0 || code !== 4'd0 || key_down !== 1'b0) begin
            $display("FAIL reset_outputs valid=%b code=%0d key_down=%b required 0/0/0", valid, code, key_down);
        end else pass_cnt++;
        total_cnt++;
        if (seg !== 8'h00 || over !== 1'b0 || dig_sel !== 2'b10) begin
            $display("FAIL reset_display seg=%h over=%b dig_sel=%b required 00/0/10", seg, over, dig_sel);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        total_cnt++;
        if (dig_sel !== 2'b01) begin
            $display("FAIL scan_toggle1 dig_sel=%b required 01", dig_sel);
        end else pass_cnt++;
        step(2);
        total_cnt++;
        if (dig_sel !== 2'b10 || seg !== 8'h00 || valid !== 1'b0) begin
            $display("FAIL scan_toggle2 dig_sel=%b seg=%h valid=%b required 10/00/0", dig_sel, seg, valid);
        end else pass_cnt++;
    endtask

    // Check the ones and tens segment patterns across one scan period.
    task automatic check_display(input logic [7:0] ones_exp, input logic [7:0] tens_exp, input string tag);
        bit seen_o = 1'b0;
        bit seen_t = 1'b0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (dig_sel == 2'b10 && !seen_o) begin
                seen_o = 1'b1;
                total_cnt++;
                if (seg !== ones_exp) $display("FAIL %s_ones seg=%h required %h", tag, seg, ones_exp);
                else pass_cnt++;
            end
            if (dig_sel == 2'b01 && !seen_t) begin
                seen_t = 1'b1;
                total_cnt++;
                if (seg !== tens_exp) $display("FAIL %s_tens seg=%h required %h", tag, seg, tens_exp);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (!(seen_o && seen_t)) $display("FAIL %s_scan seen_ones=%b seen_tens=%b required 1/1", tag, seen_o, seen_t);
        else pass_cnt++;
    endtask

    task automatic test_basic_press;
        @(negedge clk);
        data_in = 16'hFF7F;
        step(6);
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL press7_early valid=%b required 0 at edge 6", valid);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (valid !== 1'b1 || code !== 4'd7 || key_down !== 1'b1) begin
            $display("FAIL press7_latch valid=%b code=%0d key_down=%b required 1/7/1", valid, code, key_down);
        end else pass_cnt++;
        check_display(8'h07, 8'h00, "disp7");
        total_cnt++;
        if (over !== 1'b0 || valid !== 1'b1) $display("FAIL press7_hold over=%b valid=%b required 0/1", over, valid);
        else pass_cnt++;
        @(negedge clk);
        ack = 1'b1;
        step(1);
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL ack7 valid=%b required 0", valid);
        else pass_cnt++;
        @(negedge clk);
        ack = 1'b0;
        release_keys();
        total_cnt++;
        if (key_down !== 1'b0) $display("FAIL release7 key_down=%b required 0", key_down);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        int vcount = 0;
        @(negedge clk);
        data_in = 16'hFFF7;
        @(negedge clk);
        @(negedge clk);
        data_in = 16'hFFFF;
        @(negedge clk);
        data_in = 16'hFFF7;
        // The edge after this drive is the first to sample the stable low.
        step(6);
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL glitch_early valid=%b required 0", valid);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (valid !== 1'b1 || code !== 4'd3) $display("FAIL glitch_latch valid=%b code=%0d required 1/3", valid, code);
        else pass_cnt++;
        do_ack();
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (valid) vcount++;
        end
        total_cnt++;
        if (vcount !== 0) $display("FAIL glitch_single extra_valid_cycles=%0d required 0", vcount);
        else pass_cnt++;
        release_keys();
    endtask

    task automatic test_priority_over;
        int  n;
        bit  ok;
        @(negedge clk);
        data_in = 16'hEFEF;
        wait_valid(20, n, ok);
        total_cnt++;
        if (!ok || code !== 4'd12 || over !== 1'b1) begin
            $display("FAIL prio12 seen_valid=%b code=%0d over=%b required 1/12/1", ok, code, over);
        end else pass_cnt++;
        check_display(8'h5B, 8'h06, "disp12");
        do_ack();
        release_keys();
        total_cnt++;
        if (over !== 1'b1 || seg === 8'h00) $display("FAIL disp_persist over=%b seg=%h required 1/nonzero", over, seg);
        else pass_cnt++;
    endtask

    task automatic test_hold_no_retrigger;
        int  n;
        bit  ok;
        int  vcount = 0;
        @(negedge clk);
        data_in = 16'hFFDF;
        wait_valid(20, n, ok);
        total_cnt++;
        if (!ok || code !== 4'd5) $display("FAIL hold5_first seen_valid=%b code=%0d required 1/5", ok, code);
        else pass_cnt++;
        do_ack();
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (valid) vcount++;
        end
        total_cnt++;
        if (vcount !== 0) $display("FAIL hold5_retrigger valid_cycles=%0d required 0", vcount);
        else pass_cnt++;
        // Ack while valid is low must not disturb anything.
        do_ack();
        @(negedge clk);
        data_in = 16'hFFFF;
        step(6);
        @(negedge clk);
        data_in = 16'hFFDF;
        wait_valid(20, n, ok);
        total_cnt++;
        if (!ok || code !== 4'd5) $display("FAIL hold5_second seen_valid=%b code=%0d required 1/5", ok, code);
        else pass_cnt++;
        do_ack();
        release_keys();
    endtask

    task automatic test_async_reset;
        int  n;
        bit  ok;
        int  vcount = 0;
        @(negedge clk);
        data_in = 16'hF7FF;
        wait_valid(20, n, ok);
        step(3);
        total_cnt++;
        if (!ok || code !== 4'd11 || over !== 1'b1) begin
            $display("FAIL pre_reset seen_valid=%b code=%0d over=%b required 1/11/1", ok, code, over);
        end else pass_cnt++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (valid !== 1'b0 || seg !== 8'h00 || over !== 1'b0 || key_down !== 1'b0) begin
            $display("FAIL async_reset valid=%b seg=%h over=%b key_down=%b required 0/00/0/0", valid, seg, over, key_down);
        end else pass_cnt++;
        data_in = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (valid) vcount++;
        end
        total_cnt++;
        if (vcount !== 0 || code !== 4'd0) $display("FAIL post_reset valid_cycles=%0d code=%0d required 0/0", vcount, code);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_glitch();
        test_priority_over();
        test_hold_no_retrigger();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
